// File: rtl/regfile_display_reader_pkg.sv
// Shared definitions for the register-file display reader: FSM state codes,
// seven-segment constants and the double-dabble nibble adjust step.
package regfile_display_reader_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int BCD_W      = 20;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [1:0] S_ADDR  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_CONV  = 2'd2;
  localparam logic [1:0] S_LATCH = 2'd3;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  // Add 3 to every BCD nibble that is 5 or more, ahead of the next left shift.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_display_reader_seg7_decode.sv
// BCD digit to active-low seven-segment pattern {g,f,e,d,c,b,a}.
// Codes above 9 never occur on a valid display; they map to all segments off.
module seg7_decode
  import regfile_display_reader_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Table lookup with a blank fallback for non-decimal codes.
  always_comb begin
    seg = SEG_BLANK;
    if (bcd <= 4'd9) seg = SEG_DIGIT[bcd];
  end

endmodule

// File: rtl/regfile_display_reader.sv
// Reads one register selected by ext_input, converts it to decimal with a
// sequential double-dabble and drives a 4-digit multiplexed display.
//
// state   | meaning
// S_ADDR  | present ext_input to the read port and capture it
// S_WAIT  | read data arrives; load shifter, clear BCD accumulator
// S_CONV  | 16 adjust-and-shift steps
// S_LATCH | publish value, digits and overflow; pulse update
module regfile_display_reader
  import regfile_display_reader_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W-1:0] ext_input,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [3:0]        an,
  output logic [6:0]        seg,
  output logic [DATA_W-1:0] value_q,
  output logic              update,
  output logic              ovf
);

  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] src_q;
  logic [DATA_W-1:0] bin_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [3:0]        shift_cnt;
  logic [15:0]       dig_q;
  logic              valid_q;
  logic [REF_W-1:0]  refresh_cnt;
  logic [1:0]        dig_idx;
  logic [1:0]        msd;
  bcd_digit_t        cur_digit;
  logic [6:0]        dec_seg;

  // The read port is registered, so the new address is forwarded during
  // S_ADDR; the register file then returns that register's data in S_WAIT.
  assign rd_addr = (state == S_ADDR) ? ext_input : addr_q;

  // Read / convert / latch loop, 19 cycles per pass.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= S_ADDR;
      addr_q    <= '0;
      src_q     <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      shift_cnt <= '0;
      value_q   <= '0;
      dig_q     <= '0;
      ovf       <= 1'b0;
      update    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      update <= 1'b0;
      case (state)
        S_ADDR: begin
          addr_q <= ext_input;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          src_q     <= rd_data;
          bin_q     <= rd_data;
          bcd_q     <= '0;
          shift_cnt <= '0;
          state     <= S_CONV;
        end
        S_CONV: begin
          {bcd_q, bin_q} <= {dd_adjust(bcd_q), bin_q} << 1;
          shift_cnt      <= shift_cnt + 4'd1;
          if (shift_cnt == 4'(DATA_W - 1)) state <= S_LATCH;
        end
        S_LATCH: begin
          value_q <= src_q;
          dig_q   <= bcd_q[15:0];
          ovf     <= |bcd_q[19:16];
          update  <= 1'b1;
          valid_q <= 1'b1;
          state   <= S_ADDR;
        end
        default: state <= S_ADDR;
      endcase
    end
  end

  // Free-running digit scan, independent of the conversion loop.
  always_ff @(posedge clk) begin
    if (clr) begin
      refresh_cnt <= '0;
      dig_idx     <= '0;
    end else if (refresh_cnt == REF_W'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      dig_idx     <= dig_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Position of the most significant nonzero digit; digit0 is always shown.
  always_comb begin
    msd = 2'd0;
    if (dig_q[7:4]   != 4'd0) msd = 2'd1;
    if (dig_q[11:8]  != 4'd0) msd = 2'd2;
    if (dig_q[15:12] != 4'd0) msd = 2'd3;
  end

  assign cur_digit = dig_q[{dig_idx, 2'b00} +: 4];

  seg7_decode u_seg7_decode (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  // Registered anode/segment drive with blanking and overflow dashes.
  always_ff @(posedge clk) begin
    if (clr || !valid_q) begin
      an  <= ANODE_OFF;
      seg <= SEG_BLANK;
    end else if (ovf) begin
      an  <= ~(4'b0001 << dig_idx);
      seg <= SEG_DASH;
    end else if (dig_idx > msd) begin
      an  <= ANODE_OFF;
      seg <= SEG_BLANK;
    end else begin
      an  <= ~(4'b0001 << dig_idx);
      seg <= dec_seg;
    end
  end

endmodule

// File: tb/tb_regfile_display_reader.sv
// Bench for regfile_display_reader: register file model on the read port,
// table vectors, random values and multi-cycle corner sequences.
module tb_regfile_display_reader;

  logic        clk;
  logic        clr;
  logic [3:0]  ext_input;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] value_q;
  logic        update;
  logic        ovf;

  logic [15:0] mem [16];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [8];

  regfile_display_reader #(.DATA_W(16), .ADDR_W(4), .REFRESH_DIV(4)) dut (
    .clk       (clk),
    .clr       (clr),
    .ext_input (ext_input),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .an        (an),
    .seg       (seg),
    .value_q   (value_q),
    .update    (update),
    .ovf       (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered read port: data valid one cycle after the address.
  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic int pow10(input int i);
    int p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int i);
    if (v > 9999) return 7'b0111111;
    return seg_of((v / pow10(i)) % 10);
  endfunction

  function automatic bit exp_shown(input int v, input int i);
    if (v > 9999 || i == 0) return 1'b1;
    return v >= pow10(i);
  endfunction

  // Step cycles until update is seen; a missing pulse is a failed check.
  task automatic wait_update(input string name, input int max_cyc, output int cyc);
    cyc = 0;
    while (cyc < max_cyc) begin
      @(posedge clk); #1;
      cyc++;
      if (update) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: no update within %0d cycles", name, max_cyc);
  endtask

  // Watch one full scan and compare every lit digit with the model.
  task automatic check_display(input string name, input int v);
    logic [3:0] seen;
    logic [3:0] want;
    logic [3:0] onehot;
    int bad;
    int idx;
    seen = '0;
    bad = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (an != 4'b1111) begin
        idx = -1;
        for (int j = 0; j < 4; j++) begin
          onehot = 4'b0001 << j;
          if (an == ~onehot) idx = j;
        end
        if (idx < 0) bad++;
        else begin
          seen[idx] = 1'b1;
          if (seg != exp_seg(v, idx)) bad++;
        end
      end
    end
    for (int j = 0; j < 4; j++) want[j] = exp_shown(v, j);
    chk({name, " bad_digits"}, bad, 0);
    chk({name, " lit_mask"}, seen, want);
  endtask

  task automatic run_vec(input string name, input logic [3:0] a, input logic [15:0] d,
                         input logic exp_ovf);
    int cyc;
    mem[a] = d;
    ext_input = a;
    wait_update(name, 40, cyc);
    wait_update(name, 40, cyc);
    chk({name, " period"}, cyc, 19);
    chk({name, " value_q"}, value_q, d);
    chk({name, " ovf"}, ovf, exp_ovf);
    @(posedge clk); #1;
    chk({name, " rd_addr"}, rd_addr, a);
    check_display(name, int'(d));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [3:0]  ra;
    logic [15:0] rdv;

    vecs[0] = '{addr: 4'd15, data: 16'd987,   exp_ovf: 1'b0};
    vecs[1] = '{addr: 4'd0,  data: 16'd0,     exp_ovf: 1'b0};
    vecs[2] = '{addr: 4'd5,  data: 16'd65535, exp_ovf: 1'b1};
    vecs[3] = '{addr: 4'd2,  data: 16'd10000, exp_ovf: 1'b1};
    vecs[4] = '{addr: 4'd9,  data: 16'd9999,  exp_ovf: 1'b0};
    vecs[5] = '{addr: 4'd4,  data: 16'd1000,  exp_ovf: 1'b0};
    vecs[6] = '{addr: 4'd6,  data: 16'd1005,  exp_ovf: 1'b0};
    vecs[7] = '{addr: 4'd1,  data: 16'd7,     exp_ovf: 1'b0};

    for (int i = 0; i < 16; i++) mem[i] = 16'd0;
    clr = 1'b1;
    ext_input = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset an", an, 4'b1111);
    chk("reset seg", seg, 7'b1111111);
    chk("reset value_q", value_q, 0);
    chk("reset update", update, 0);
    chk("reset ovf", ovf, 0);
    chk("reset rd_addr", rd_addr, 0);

    clr = 1'b0;
    wait_update("first", 40, cyc);
    chk("first latency", cyc, 19);

    for (int i = 0; i < 8; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].exp_ovf);

    // Select change during conversion: in-flight pass keeps the old address.
    mem[3] = 16'd3;
    mem[7] = 16'd21;
    ext_input = 4'd3;
    wait_update("midsel", 40, cyc);
    wait_update("midsel", 40, cyc);
    chk("midsel pre value", value_q, 3);
    repeat (5) @(posedge clk);
    #1;
    ext_input = 4'd7;
    wait_update("midsel", 40, cyc);
    chk("midsel first value", value_q, 3);
    wait_update("midsel", 40, cyc);
    chk("midsel second value", value_q, 21);

    // Reset during conversion aborts the pass and blanks the display.
    repeat (6) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk); #1;
    chk("midrst update", update, 0);
    chk("midrst value_q", value_q, 0);
    chk("midrst an", an, 4'b1111);
    chk("midrst ovf", ovf, 0);
    clr = 1'b0;
    wait_update("midrst", 40, cyc);
    chk("midrst latency", cyc, 19);
    chk("midrst value", value_q, 21);

    for (int i = 0; i < 20; i++) begin
      ra  = 4'($urandom_range(0, 15));
      rdv = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 9999))
                                        : 16'($urandom_range(0, 65535));
      run_vec($sformatf("rnd%0d", i), ra, rdv, rdv > 16'd9999);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_display_reader.md
Name: regfile_display_reader

Overview:
Read-side companion to the Fibonacci memory controller. Continuously reads one register of the 16x16 register file through its read port, selected by ext_input. Converts the 16-bit value to decimal using a sequential double-dabble, and drives the 4-digit multiplexed active-low seven-segment display. It owns the display path; the controller only writes registers.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 4, register address width (16 registers)
REFRESH_DIV, 50000, clk cycles per digit before the scan advances (about 500 Hz per digit at 100 MHz)

Ports:
clk  in  1  system clock, all logic on its rising edge
clr  in  1  synchronous, active-high reset
ext_input  in  ADDR_W  register select, 0-15 selects r0-r15
rd_addr  out  ADDR_W  register file read address
rd_data  in  DATA_W  register file read data, registered, valid one cycle after rd_addr
an  out  4  digit anodes, active-low, an[0] is the rightmost digit
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
value_q  out  DATA_W  last latched register value
update  out  1  one-cycle pulse when value_q and the display digits are refreshed
ovf  out  1  latched value is greater than 9999

Behaviour:
- Reset (clr=1 at a rising edge):
  - FSM goes to S_ADDR.
  - rd_addr=0, value_q=0, update=0, ovf=0.
  - Display invalid: an=4'b1111, seg=7'b1111111.
  - Scan counter and digit index go to 0.
  - clr asserted mid-conversion aborts the conversion; no update pulse is produced.
- FSM loop, 19 cycles per iteration, repeats forever:
  - S_ADDR (1 cycle): latch ext_input into rd_addr.
  - S_WAIT (1 cycle): the register file returns data. On exit, load rd_data into the binary shift register and clear the 20-bit BCD accumulator.
  - S_CONV (16 cycles): each cycle, add 3 to every BCD nibble that is >=5, then shift {bcd,bin} left by 1. A 4-bit counter ends the state after exactly 16 shifts.
  - S_LATCH (1 cycle): copy the bin source value into value_q and the 4 low BCD nibbles into the display digit registers. Set ovf when the top nibble is nonzero. Pulse update=1 and set display valid. Next state is S_ADDR.
- Latency: from the S_ADDR that samples ext_input to update is 19 cycles. The display reflects a register write at most 2 iterations (38 cycles) later.
- ext_input changes outside S_ADDR are ignored until the next S_ADDR; the current conversion always completes with the old address.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1. On wrap, the digit index advances 0->1->2->3->0.
  - The scan runs independently of the FSM; a latch never resets the scan counter.
  - an is one-hot low for the active digit: digit0 = 4'b1110.
- Leading-zero blanking: a digit above the most significant nonzero digit has an=1111 for its slot. Digit0 is always shown, so value 0 displays "0".
- ovf=1: all four digits show a dash (seg=7'b0111111) and no blanking is applied.
- Display invalid (after reset, before the first update): an=4'b1111.
- Segment encoding:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- Outputs an and seg are registered (one cycle after the digit index changes).

Decomposition:
- Shared package:
  - FSM state encodings (S_ADDR, S_WAIT, S_CONV, S_LATCH)
  - segment constants SEG_BLANK, SEG_DASH, SEG_DIGIT[0:9]
  - ANODE_OFF
  - DATA_W and ADDR_W defaults
- One sub-module: seg7_decode, a combinational 4-bit BCD to active-low 7-segment decoder instantiated once on the scanned digit mux output. The double-dabble stays inline in the FSM.

Test Plan:
- Reset: hold clr 3 cycles, then sample -> an=1111, seg=1111111, value_q=0, update=0, ovf=0, rd_addr=0.
- Select r15: ext_input=15, register file model returns 987 for address 15 -> rd_addr=15; update pulses exactly 19 cycles after S_ADDR; value_q=987, ovf=0. Scanning with REFRESH_DIV=4 gives digit0 seg=1111000 (7), digit1 0000000 (8), digit2 0010000 (9), digit3 an=1111 (blanked).
- Zero: address 0 returns 0 -> only digit0 is lit, with seg=1000000; an is 1111 for digits 1-3.
- Overflow: data=65535 -> value_q=16'hFFFF, ovf=1, all four digits seg=0111111.
- Mid-conversion select change: switch ext_input 3->7 during S_CONV (r3=3, r7=21) -> the first update gives value_q=3; the next update gives value_q=21.
- Reset mid-operation: assert clr during S_CONV -> no update pulse; value_q=0 and an=1111 on the next cycle. The loop restarts and the first update arrives 19 cycles after clr is released.
